// File: rtl/bch_chien_search.sv
// Chien search over GF(2^M): evaluates the error locator at every codeword
// position, most significant bit first, and reports the root count.
module bch_chien_search #(
  parameter int M = 4,
  parameter int T = 2,
  parameter int N = 15,
  parameter logic [M:0] PRIM_POLY = 5'b10011,
  localparam int ES = $clog2(T + 2)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [(T+1)*M-1:0] sigma,
  input  logic [ES-1:0]      err_count,
  output logic               accepted,
  output logic               busy,
  output logic               err_valid,
  output logic               err_bit,
  output logic               err_first,
  output logic               err_last,
  output logic               done,
  output logic [ES-1:0]      err_found,
  output logic               uncorrectable
);

  localparam int PW = (N > 2) ? $clog2(N) : 1;
  localparam logic [PW-1:0] POS_TOP = PW'(N - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  function automatic logic [M-1:0] gf_mul(
    input logic [M-1:0] a,
    input logic [M-1:0] b
  );
    logic [M-1:0] p;
    logic [M-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) p = p ^ x;
      x = x[M-1] ? ((x << 1) ^ PRIM_POLY[M-1:0]) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [M-1:0] gf_pow(input int e);
    logic [M-1:0] v;
    int k;
    v = M'(1);
    k = e % ((1 << M) - 1);
    for (int i = 0; i < k; i++) v = gf_mul(v, M'(2));
    return v;
  endfunction

  logic [1:0]    state;
  logic [PW-1:0] pos;
  logic [M-1:0]  s0;
  logic [ES-1:0] cnt_q;
  logic [M-1:0]  r      [1:T];
  logic [M-1:0]  r_init [1:T];
  logic [M-1:0]  r_step [1:T];
  logic [M-1:0]  sum;

  // Preload shifts evaluation to alpha^-(N-1) for shortened codes.
  for (genvar j = 1; j <= T; j++) begin : g_mul
    localparam logic [M-1:0] INIT = gf_pow(j * ((1 << M) - N));
    localparam logic [M-1:0] STEP = gf_pow(j);
    assign r_init[j] = gf_mul(sigma[j*M +: M], INIT);
    assign r_step[j] = gf_mul(r[j], STEP);
  end

  always_comb begin
    sum = s0;
    for (int j = 1; j <= T; j++) sum = sum ^ r[j];
  end

  assign accepted      = start && rst_n && (state == IDLE);
  assign busy          = (state == RUN) || (state == FINISH);
  assign err_valid     = (state == RUN);
  assign err_bit       = err_valid && (sum == '0);
  assign err_first     = err_valid && (pos == POS_TOP);
  assign err_last      = err_valid && (pos == '0);
  assign done          = (state == FINISH);
  assign uncorrectable = done && ((err_found != cnt_q) || (s0 == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pos       <= '0;
      s0        <= '0;
      cnt_q     <= '0;
      err_found <= '0;
      for (int j = 1; j <= T; j++) r[j] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accepted) begin
            state     <= RUN;
            pos       <= POS_TOP;
            s0        <= sigma[0 +: M];
            cnt_q     <= err_count;
            err_found <= '0;
            for (int j = 1; j <= T; j++) r[j] <= r_init[j];
          end
        end
        RUN: begin
          for (int j = 1; j <= T; j++) r[j] <= r_step[j];
          pos <= pos - PW'(1);
          if (err_bit && (err_found != '1))
            err_found <= err_found + ES'(1);
          if (pos == '0) state <= FINISH;
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_chien_search.sv
// Directed bench for bch_chien_search, GF(16), T=2, N=15.
// Locator vectors and root positions are worked by hand.
module tb_bch_chien_search;

  localparam int M  = 4;
  localparam int T  = 2;
  localparam int N  = 15;
  localparam int ES = 2;

  logic              clk = 0;
  logic              rst_n = 0;
  logic              start = 0;
  logic [(T+1)*M-1:0] sigma = '0;
  logic [ES-1:0]     err_count = '0;
  logic              accepted, busy, err_valid, err_bit;
  logic              err_first, err_last, done, uncorrectable;
  logic [ES-1:0]     err_found;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bch_chien_search #(.M(M), .T(T), .N(N), .PRIM_POLY(5'b10011)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sigma(sigma),
    .err_count(err_count), .accepted(accepted), .busy(busy),
    .err_valid(err_valid), .err_bit(err_bit), .err_first(err_first),
    .err_last(err_last), .done(done), .err_found(err_found),
    .uncorrectable(uncorrectable)
  );

  task automatic test_reset();
    rst_n = 0;
    start = 1;
    sigma = 12'h081;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({accepted, busy, err_valid, err_bit, err_first, err_last,
         done, uncorrectable, err_found} !== 10'b0) begin
      fails++;
      $display("FAIL reset_outputs got=%b want=0", {accepted, busy,
        err_valid, err_bit, err_first, err_last, done, uncorrectable,
        err_found});
    end
    start = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic run_cw(
    input string            name,
    input logic [11:0]      sig,
    input logic [ES-1:0]    cnt,
    input logic [N-1:0]     mask,
    input logic [ES-1:0]    found,
    input logic             unc
  );
    @(negedge clk);
    start = 1;
    sigma = sig;
    err_count = cnt;
    #1;
    tests++;
    if (accepted !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s accept got=%b%b want=10", name, accepted, busy);
    end
    @(negedge clk);
    start = 0;
    sigma = '0;
    err_count = '0;
    for (int k = 0; k < N; k++) begin
      tests++;
      if (err_valid !== 1'b1 || busy !== 1'b1 ||
          err_bit !== mask[N-1-k] || err_first !== (k == 0) ||
          err_last !== (k == N - 1) || done !== 1'b0) begin
        fails++;
        $display("FAIL %s cycle%0d vbit_fl_d got=%b%b%b%b%b%b want=11%b%b%b0",
          name, k, err_valid, busy, err_bit, err_first, err_last, done,
          mask[N-1-k], k == 0, k == N - 1);
      end
      @(negedge clk);
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b1 || err_valid !== 1'b0 ||
        err_found !== found || uncorrectable !== unc) begin
      fails++;
      $display("FAIL %s finish done=%b busy=%b valid=%b found=%0d unc=%b want 1 1 0 %0d %b",
        name, done, busy, err_valid, err_found, uncorrectable, found, unc);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || uncorrectable !== 1'b0) begin
      fails++;
      $display("FAIL %s idle done=%b busy=%b unc=%b want 000",
        name, done, busy, uncorrectable);
    end
  endtask

  task automatic test_single_error();
    run_cw("single", 12'h081, 2'd1, 15'h0008, 2'd1, 1'b0);
  endtask

  task automatic test_edge_errors();
    run_cw("edges", 12'h981, 2'd2, 15'h4001, 2'd2, 1'b0);
  endtask

  task automatic test_no_error();
    run_cw("none", 12'h001, 2'd0, 15'h0000, 2'd0, 1'b0);
  endtask

  task automatic test_no_roots();
    run_cw("noroots", 12'h118, 2'd2, 15'h0000, 2'd0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int nvalid = 0;
    int nbits = 0;
    int ndone = 0;
    @(negedge clk);
    start = 1;
    sigma = 12'h081;
    err_count = 2'd1;
    for (int i = 0; i < 2 * (N + 2); i++) begin
      #1;
      tests++;
      if (accepted !== (i % (N + 2) == 0) ||
          busy !== (i % (N + 2) != 0)) begin
        fails++;
        $display("FAIL b2b cycle%0d acc=%b busy=%b want %b %b", i,
          accepted, busy, i % (N + 2) == 0, i % (N + 2) != 0);
      end
      nvalid += int'(err_valid);
      nbits  += int'(err_bit);
      ndone  += int'(done);
      @(negedge clk);
    end
    start = 0;
    tests++;
    if (nvalid != 2 * N || nbits != 2 || ndone != 2) begin
      fails++;
      $display("FAIL b2b_counts valid=%0d bits=%0d done=%0d want %0d 2 2",
        nvalid, nbits, ndone, 2 * N);
    end
  endtask

  task automatic test_mid_reset();
    int stray = 0;
    @(negedge clk);
    start = 1;
    sigma = 12'h081;
    err_count = 2'd1;
    @(negedge clk);
    start = 0;
    repeat (6) @(negedge clk);
    tests++;
    if (err_valid !== 1'b1) begin
      fails++;
      $display("FAIL midrst_run7 valid=%b want 1", err_valid);
    end
    rst_n = 0;
    @(negedge clk);
    start = 1;
    #1;
    tests++;
    if ({accepted, busy, err_valid, err_bit, err_first, err_last,
         done, uncorrectable, err_found} !== 10'b0) begin
      fails++;
      $display("FAIL midrst_outputs got=%b want=0", {accepted, busy,
        err_valid, err_bit, err_first, err_last, done, uncorrectable,
        err_found});
    end
    start = 0;
    rst_n = 1;
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      stray += int'(err_valid) + int'(done) + int'(busy);
    end
    tests++;
    if (stray != 0) begin
      fails++;
      $display("FAIL midrst_silent stray=%0d want 0", stray);
    end
  endtask

  task automatic test_recover();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    run_cw("recover", 12'h081, 2'd1, 15'h0008, 2'd1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_error();
    test_edge_errors();
    test_no_error();
    test_no_roots();
    test_back_to_back();
    test_mid_reset();
    test_recover();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
